sys_clk_div_mgr: RTL and testbench

Lock-qualified, parametrised clock-enable and divided-clock generator for WIB system clocking. It sits directly downstream of the system PLL and runs on one PLL output clock. It qualifies the PLL lock indication over a programmable stable window, then generates N_CH independently divisible, phase-aligned enable strobes and 50%-nominal divided clocks. It also supports runtime reload of divide ratios and counts lock-loss events for slow-control readback.

---
 rtl/sys_clk_div_mgr.sv | 147 ++++++++++++++
 tb/tb_sys_clk_div_mgr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_clk_div_mgr.sv
// sys_clk_div_mgr: lock-qualified clock-enable / divided-clock generator.
// Synchronises the raw PLL lock, qualifies it over LOCK_CYC cycles, then
// drives N_CH phase-aligned enable strobes and ~50% divided clocks with
// runtime-reloadable ratios. Lock losses are counted for readback.
module sys_clk_div_mgr #(
  parameter int N_CH     = 3,
  parameter int DIV_W    = 8,
  parameter int DIV_RST  = 2,
  parameter int LOCK_CYC = 1024,
  parameter int LOSS_W   = 8
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [N_CH*DIV_W-1:0]   div_val,
  input  logic                    div_load,
  input  logic                    loss_clr,
  output logic                    locked,
  output logic [N_CH-1:0]         ce_out,
  output logic [N_CH-1:0]         div_clk,
  output logic [LOSS_W-1:0]       loss_cnt
);

  localparam int QW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(LOCK_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              lk_m;
  logic              lk_s;
  logic [QW-1:0]     qcnt;
  logic              loss_evt;

  logic [DIV_W-1:0]  div_r  [N_CH];
  logic [DIV_W-1:0]  cnt_r  [N_CH];
  logic [DIV_W-1:0]  div_nx [N_CH];
  logic [DIV_W-1:0]  cnt_nx [N_CH];
  logic [DIV_W:0]    half   [N_CH];
  logic [N_CH-1:0]   ce_nx;
  logic [N_CH-1:0]   clk_nx;
  logic              locked_nx;

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
    end
  end

  // FSM state register
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_LOCK: if (lk_s) state_nx = QUALIFY;
      QUALIFY: begin
        if (!lk_s)               state_nx = WAIT_LOCK;
        else if (qcnt == Q_LAST) state_nx = RUN;
      end
      RUN:     if (!lk_s) state_nx = WAIT_LOCK;
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // Qualification counter: held at zero outside QUALIFY so entry always starts at 0
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
    end else if (state != QUALIFY) begin
      qcnt <= '0;
    end else if (lk_s && qcnt != Q_LAST) begin
      qcnt <= qcnt + QW'(1);
    end
  end

  assign loss_evt = (state == RUN) && !lk_s;

  // Saturating lock-loss counter; a clear coincident with a loss leaves 1
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (loss_clr) begin
      loss_cnt <= loss_evt ? LOSS_W'(1) : '0;
    end else if (loss_evt && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  // Output logic: next ratio, next phase and next registered outputs per channel.
  // Outputs are computed from the post-edge phase so they can be registered
  // while still showing j=0 in the first cycle after RUN entry or a reload.
  always_comb begin
    locked_nx = (state_nx == RUN);
    ce_nx     = '0;
    clk_nx    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      div_nx[i] = div_load ? div_val[i*DIV_W +: DIV_W] : div_r[i];
      cnt_nx[i] = '0;
      if (locked_nx && state == RUN && !div_load && div_r[i] != '0) begin
        if (cnt_r[i] == div_r[i] - DIV_W'(1)) cnt_nx[i] = '0;
        else                                  cnt_nx[i] = cnt_r[i] + DIV_W'(1);
      end
      half[i]   = ({1'b0, div_nx[i]} + (DIV_W+1)'(1)) >> 1;
      ce_nx[i]  = locked_nx && (div_nx[i] != '0) &&
                  (cnt_nx[i] == div_nx[i] - DIV_W'(1));
      clk_nx[i] = locked_nx && (div_nx[i] != '0) &&
                  ({1'b0, cnt_nx[i]} < half[i]);
    end
  end

  // Ratio, phase and output registers
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      ce_out  <= '0;
      div_clk <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        div_r[i] <= DIV_W'(DIV_RST);
        cnt_r[i] <= '0;
      end
    end else begin
      locked  <= locked_nx;
      ce_out  <= ce_nx;
      div_clk <= clk_nx;
      for (int unsigned i = 0; i < N_CH; i++) begin
        div_r[i] <= div_nx[i];
        cnt_r[i] <= cnt_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_sys_clk_div_mgr.sv
// Self-checking bench for sys_clk_div_mgr: directed sequences and a
// constant-vector reload table, plus randomized traffic compared each cycle
// against a behavioural model (consecutive-lock count and j mod D arithmetic).
module tb_sys_clk_div_mgr;

  localparam int N_CH     = 3;
  localparam int DIV_W    = 8;
  localparam int DIV_RST  = 2;
  localparam int LOCK_CYC = 16;
  localparam int LOSS_W   = 2;
  localparam int LOSS_MAX = (1 << LOSS_W) - 1;

  logic                  refclk = 1'b0;
  logic                  rst_n;
  logic                  pll_locked;
  logic [N_CH*DIV_W-1:0] div_val;
  logic                  div_load;
  logic                  loss_clr;
  logic                  locked;
  logic [N_CH-1:0]       ce_out;
  logic [N_CH-1:0]       div_clk;
  logic [LOSS_W-1:0]     loss_cnt;

  int n_err = 0;
  int n_chk = 0;

  sys_clk_div_mgr #(
    .N_CH(N_CH), .DIV_W(DIV_W), .DIV_RST(DIV_RST),
    .LOCK_CYC(LOCK_CYC), .LOSS_W(LOSS_W)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .div_val(div_val), .div_load(div_load), .loss_clr(loss_clr),
    .locked(locked), .ce_out(ce_out), .div_clk(div_clk), .loss_cnt(loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_p1, m_p2, m_run;
  int m_hi, m_j, m_loss;
  int m_d [N_CH];

  initial begin : model
    bit lks, nrun;
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) begin
        m_p1 = 0; m_p2 = 0; m_run = 0; m_hi = 0; m_j = 0; m_loss = 0;
        for (int i = 0; i < N_CH; i++) m_d[i] = DIV_RST;
      end else begin
        lks  = m_p2;
        m_p2 = m_p1;
        m_p1 = pll_locked;
        if (!lks) m_hi = 0;
        else if (m_hi < 100000) m_hi = m_hi + 1;
        // RUN once lk_s has been seen high on LOCK_CYC+1 consecutive edges
        nrun = (m_hi >= LOCK_CYC + 1);
        if (m_run && !nrun) m_loss = loss_clr ? 1 : ((m_loss < LOSS_MAX) ? m_loss + 1 : LOSS_MAX);
        else if (loss_clr) m_loss = 0;
        if (div_load)
          for (int i = 0; i < N_CH; i++) m_d[i] = int'(div_val[i*DIV_W +: DIV_W]);
        if (nrun) m_j = (!m_run || div_load) ? 0 : m_j + 1;
        m_run = nrun;
      end
    end
  end

  initial begin : model_cmp
    logic [N_CH-1:0] e_ce, e_clk;
    forever begin
      @(negedge refclk);
      if (rst_n === 1'b1) begin
        for (int i = 0; i < N_CH; i++) begin
          e_ce[i]  = m_run && m_d[i] > 0 && (m_j % m_d[i] == m_d[i] - 1);
          e_clk[i] = m_run && m_d[i] > 0 && (m_j % m_d[i] < (m_d[i] + 1) / 2);
        end
        chk("model_locked", 32'(locked), 32'(m_run));
        chk("model_ce", 32'(ce_out), 32'(e_ce));
        chk("model_clk", 32'(div_clk), 32'(e_clk));
        chk("model_loss", 32'(loss_cnt), 32'(m_loss));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; div_load = 1'b0; loss_clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_lock();
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      if (locked === 1'b1) ok = 1;
    end
    chk("lock_timeout", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic            ld;
    logic [N_CH-1:0] ce;
    logic [N_CH-1:0] clk;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit seen;
    // reload table: div_val = {ch2=5, ch1=1, ch0=0}; rows 7 and 8 reload back-to-back
    tbl[0]  = '{1'b1, 3'b010, 3'b110};  // j=0
    tbl[1]  = '{1'b0, 3'b010, 3'b110};  // j=1
    tbl[2]  = '{1'b0, 3'b010, 3'b110};  // j=2
    tbl[3]  = '{1'b0, 3'b010, 3'b010};  // j=3
    tbl[4]  = '{1'b0, 3'b110, 3'b010};  // j=4
    tbl[5]  = '{1'b0, 3'b010, 3'b110};  // j=5 -> 0
    tbl[6]  = '{1'b0, 3'b010, 3'b110};  // j=6 -> 1
    tbl[7]  = '{1'b1, 3'b010, 3'b110};  // realigned j=0
    tbl[8]  = '{1'b1, 3'b010, 3'b110};  // realigned j=0
    tbl[9]  = '{1'b0, 3'b010, 3'b110};
    tbl[10] = '{1'b0, 3'b010, 3'b110};
    tbl[11] = '{1'b0, 3'b010, 3'b010};
    tbl[12] = '{1'b0, 3'b110, 3'b010};

    div_val = {8'd2, 8'd2, 8'd2};

    // reset state
    do_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ce", 32'(ce_out), 32'd0);
    chk("rst_clk", 32'(div_clk), 32'd0);
    chk("rst_loss", 32'(loss_cnt), 32'd0);

    // lock acquisition: pll high before edge 0 -> locked at edge LOCK_CYC+2
    pll_locked = 1'b1;
    for (int e = 0; e <= LOCK_CYC + 2; e++) begin
      step();
      chk("acq_locked", 32'(locked), 32'(e == LOCK_CYC + 2));
    end
    chk("acq_ce_j0", 32'(ce_out), 32'b000);
    chk("acq_clk_j0", 32'(div_clk), 32'b111);
    step();
    chk("acq_ce_j1", 32'(ce_out), 32'b111);
    chk("acq_clk_j1", 32'(div_clk), 32'b000);
    step();
    chk("acq_ce_j2", 32'(ce_out), 32'b000);
    chk("acq_clk_j2", 32'(div_clk), 32'b111);

    // runtime reload table
    for (int r = 0; r < 13; r++) begin
      div_val  = {8'd5, 8'd1, 8'd0};
      div_load = tbl[r].ld;
      step();
      div_load = 1'b0;
      chk($sformatf("tbl_ce[%0d]", r), 32'(ce_out), 32'(tbl[r].ce));
      chk($sformatf("tbl_clk[%0d]", r), 32'(div_clk), 32'(tbl[r].clk));
    end
    div_val = {8'd2, 8'd2, 8'd2};
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("restore_clk", 32'(div_clk), 32'b111);

    // loss counting and saturation
    for (int k = 0; k < 5; k++) begin
      pll_locked = 1'b0;
      step(); chk("loss_m0", 32'(locked), 32'd1);
      step(); chk("loss_m1", 32'(locked), 32'd1);
      step(); chk("loss_m2", 32'(locked), 32'd0);
      chk("loss_outs", 32'({ce_out, div_clk}), 32'd0);
      chk("loss_cnt", 32'(loss_cnt), 32'((k + 1 < LOSS_MAX) ? k + 1 : LOSS_MAX));
      pll_locked = 1'b1;
      wait_lock();
    end

    // clear coincident with a loss gives 1; clear alone gives 0
    pll_locked = 1'b0;
    step(); step();
    loss_clr = 1'b1;
    step();
    loss_clr = 1'b0;
    chk("clr_coinc", 32'(loss_cnt), 32'd1);
    loss_clr = 1'b1;
    step();
    loss_clr = 1'b0;
    chk("clr_alone", 32'(loss_cnt), 32'd0);

    // async reset in RUN mid-ce pulse; ratios return to DIV_RST
    pll_locked = 1'b1;
    wait_lock();
    div_val = {8'd3, 8'd3, 8'd3};
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (ce_out != '0) seen = 1;
    end
    chk("ce_timeout", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_outs", 32'({ce_out, div_clk}), 32'd0);
    chk("arst_loss", 32'(loss_cnt), 32'd0);
    step(); step();
    rst_n = 1'b1;
    wait_lock();
    chk("arst_d_ce0", 32'(ce_out), 32'b000);
    chk("arst_d_clk0", 32'(div_clk), 32'b111);
    step();
    chk("arst_d_ce1", 32'(ce_out), 32'b111);
    chk("arst_d_clk1", 32'(div_clk), 32'b000);

    // qualification abort: high 10, low 3, high again -> RUN 18 edges after the second rise
    do_reset();
    for (int e = 0; e <= 31; e++) begin
      pll_locked = (e < 10 || e >= 13);
      step();
      chk("abort_locked", 32'(locked), 32'(e == 31));
    end
    chk("abort_loss", 32'(loss_cnt), 32'd0);

    // randomized traffic, checked by the reference model every cycle
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      div_load = ($urandom_range(0, 15) == 0);
      if (div_load)
        for (int i = 0; i < N_CH; i++) div_val[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
      loss_clr = ($urandom_range(0, 31) == 0);
      step();
    end
    div_load = 1'b0;
    loss_clr = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
